// File: rtl/pc_unit.sv
// Program counter with trap/EPC handling and a circular return-address stack.
// Redirect targets are alignment-checked; a misaligned target diverts to TRAP_VECTOR.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h80),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             ret,
  input  logic             trap,
  input  logic             trap_return,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misaligned,
  output logic             ras_underflow
);

  localparam int unsigned      PtrW      = $clog2(RAS_DEPTH);
  localparam int unsigned      CntW      = PtrW + 1;
  localparam logic [WIDTH-1:0] StepW     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] AlignMask = WIDTH'(STEP - 1);
  localparam logic [CntW-1:0]  CntFull   = CntW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0]  sp_q, sp_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             uf_q, uf_d;
  logic             do_push, do_pop, redirect;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] ras_top;

  function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
    return (addr & AlignMask) != '0;
  endfunction

  // sp_q points at the next free slot; a push when full lands on the oldest entry.
  assign ras_top = ras_q[sp_q - PtrW'(1)];
  assign pc_plus = pc_q + StepW;

  always_comb begin
    pc_d     = pc_plus;
    epc_d    = epc_q;
    mis_d    = 1'b0;
    uf_d     = uf_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    redirect = 1'b0;
    tgt      = '0;
    if (trap) begin
      pc_d  = TRAP_VECTOR;
      epc_d = pc_q;
    end else if (trap_return) begin
      pc_d = epc_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (ret) begin
      if (cnt_q != '0) begin
        redirect = 1'b1;
        tgt      = ras_top;
        do_pop   = 1'b1;
      end else begin
        uf_d = 1'b1;
      end
    end else if (call || jump) begin
      redirect = 1'b1;
      tgt      = jump_target;
      do_push  = call;
    end else if (branch_taken) begin
      redirect = 1'b1;
      tgt      = branch_target;
    end

    if (redirect) begin
      if (is_misaligned(tgt)) begin
        pc_d    = TRAP_VECTOR;
        epc_d   = pc_q;
        mis_d   = 1'b1;
        do_push = 1'b0;
        do_pop  = 1'b0;
      end else begin
        pc_d = tgt;
      end
    end
  end

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (do_push) begin
      sp_d  = sp_q + PtrW'(1);
      cnt_d = (cnt_q == CntFull) ? cnt_q : cnt_q + CntW'(1);
    end else if (do_pop) begin
      sp_d  = sp_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
      uf_q  <= uf_d;
    end
  end

  // Entry storage needs no reset: the count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      ras_q[sp_q] <= pc_plus;
    end
  end

  assign pc            = pc_q;
  assign epc           = epc_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CntFull);
  assign misaligned    = mis_q;
  assign ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit at default parameters.
// Stimulus pushes expected state per edge; a monitor pops and compares after each edge/reset.
module tb_pc_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall, branch_taken, jump, call, ret, trap, trap_return;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus, epc;
  logic        ras_empty, ras_full, misaligned, ras_underflow;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [3:0]  flags;  // {ras_empty, ras_full, misaligned, ras_underflow}
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  pc_unit dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .call         (call),
    .jump_target  (jump_target),
    .ret          (ret),
    .trap         (trap),
    .trap_return  (trap_return),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .epc          (epc),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .misaligned   (misaligned),
    .ras_underflow(ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Monitor: DUT state is presented after every clock edge and on async reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock or posedge reset);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".pc"}, pc, e.pc);
        chk({e.name, ".pc_plus"}, pc_plus, e.pc + 32'd4);
        chk({e.name, ".epc"}, epc, e.epc);
        chk({e.name, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, e.flags[3]});
        chk({e.name, ".ras_full"}, {31'b0, ras_full}, {31'b0, e.flags[2]});
        chk({e.name, ".misaligned"}, {31'b0, misaligned}, {31'b0, e.flags[1]});
        chk({e.name, ".ras_underflow"}, {31'b0, ras_underflow}, {31'b0, e.flags[0]});
      end
    end
  end

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; trap = 0; trap_return = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic expect_state(input string nm, input logic [31:0] p, input logic [31:0] ep,
                              input logic [3:0] fl);
    sb.push_back('{name: nm, pc: p, epc: ep, flags: fl});
  endtask

  // Inputs already driven; one clock edge, then back to idle on the falling edge.
  task automatic step(input string nm, input logic [31:0] p, input logic [31:0] ep,
                      input logic [3:0] fl);
    expect_state(nm, p, ep, fl);
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    expect_state("reset", 32'h0, 32'h0, 4'b1000);
    #1 reset = 1;
    @(negedge clock);
    reset = 0;

    step("idle1", 32'h4, 32'h0, 4'b1000);
    step("idle2", 32'h8, 32'h0, 4'b1000);
    step("idle3", 32'hC, 32'h0, 4'b1000);
    step("idle4", 32'h10, 32'h0, 4'b1000);

    call = 1; jump_target = 32'h100;
    step("call100", 32'h100, 32'h0, 4'b0000);
    ret = 1;
    step("ret14", 32'h14, 32'h0, 4'b1000);

    call = 1; jump_target = 32'h200;
    step("call_a", 32'h200, 32'h0, 4'b0000);
    call = 1; jump_target = 32'h300;
    step("call_b", 32'h300, 32'h0, 4'b0000);
    call = 1; jump = 1; jump_target = 32'h400;
    step("call_jump_c", 32'h400, 32'h0, 4'b0000);
    call = 1; jump_target = 32'h500;
    step("call_d", 32'h500, 32'h0, 4'b0100);
    call = 1; jump_target = 32'h600;
    step("call_e_wrap", 32'h600, 32'h0, 4'b0100);

    ret = 1; step("ret1", 32'h504, 32'h0, 4'b0000);
    ret = 1; step("ret2", 32'h404, 32'h0, 4'b0000);
    ret = 1; step("ret3", 32'h304, 32'h0, 4'b0000);
    ret = 1; step("ret4", 32'h204, 32'h0, 4'b1000);
    ret = 1; step("ret5_underflow", 32'h208, 32'h0, 4'b1001);

    ret = 1; call = 1; jump_target = 32'h700;
    step("ret_beats_call", 32'h20C, 32'h0, 4'b1001);

    jump = 1; jump_target = 32'h20;
    step("jump20", 32'h20, 32'h0, 4'b1001);
    stall = 1; branch_taken = 1; branch_target = 32'h40;
    step("stall_branch", 32'h20, 32'h0, 4'b1001);
    stall = 1; call = 1; jump_target = 32'h300;
    step("stall_call", 32'h20, 32'h0, 4'b1001);
    stall = 1; trap = 1;
    step("trap_in_stall", 32'h80, 32'h20, 4'b1001);
    trap_return = 1;
    step("trap_return", 32'h20, 32'h20, 4'b1001);

    step("idle24", 32'h24, 32'h20, 4'b1001);
    branch_taken = 1; branch_target = 32'h30;
    step("branch30", 32'h30, 32'h20, 4'b1001);
    jump = 1; jump_target = 32'h102;
    step("jump_misaligned", 32'h80, 32'h30, 4'b1011);
    step("mis_clears", 32'h84, 32'h30, 4'b1001);
    branch_taken = 1; branch_target = 32'h41;
    step("branch_misaligned", 32'h80, 32'h84, 4'b1011);
    step("idle84", 32'h84, 32'h84, 4'b1001);
    call = 1; jump_target = 32'h2;
    step("call_misaligned", 32'h80, 32'h84, 4'b1011);
    step("idle84b", 32'h84, 32'h84, 4'b1001);

    jump = 1; jump_target = 32'hFFFF_FFFC;
    step("jump_top", 32'hFFFF_FFFC, 32'h84, 4'b1001);
    step("wrap", 32'h0, 32'h84, 4'b1001);
    step("after_wrap", 32'h4, 32'h84, 4'b1001);

    // Reset lands between edges with a stalled trap pending.
    stall = 1; trap = 1;
    expect_state("async_reset", 32'h0, 32'h0, 4'b1000);
    #2 reset = 1;
    @(negedge clock);
    reset = 0;
    idle_inputs();
    step("post_reset", 32'h4, 32'h0, 4'b1000);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the address width of every address port.
REQ-002 SHALL have parameter STEP, default 4, giving the sequential increment; it SHALL be a power of two, at least 1.
REQ-003 SHALL have parameter RESET_VECTOR, default 0, giving the PC value loaded on reset.
REQ-004 SHALL have parameter TRAP_VECTOR, default 'h80, giving the PC value loaded on a trap or a misaligned redirect.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, giving the number of return-address-stack entries; it SHALL be a power of two, at least 2.
REQ-006 SHALL have the following ports, one per line: name, direction, width, meaning.
  clock  input  1  single clock; all state updates on rising edge
  reset  input  1  asynchronous, active-high reset
  stall  input  1  hold PC, EPC and RAS
  branch_taken  input  1  take branch_target
  branch_target  input  WIDTH  conditional redirect address
  jump  input  1  take jump_target
  call  input  1  take jump_target and push pc+STEP
  jump_target  input  WIDTH  address for jump/call
  ret  input  1  pop RAS into PC
  trap  input  1  exception request
  trap_return  input  1  resume at EPC
  pc  output  WIDTH  current PC (registered)
  pc_plus  output  WIDTH  pc+STEP (combinational)
  epc  output  WIDTH  saved exception PC (registered)
  ras_empty  output  1  RAS count == 0
  ras_full  output  1  RAS count == RAS_DEPTH
  misaligned  output  1  one-cycle pulse: redirect target rejected
  ras_underflow  output  1  sticky: ret with empty RAS

Function
REQ-007 SHALL compute next pc on each rising edge using this fixed priority: trap > trap_return > stall > ret > call/jump > branch_taken > sequential (pc+STEP).
REQ-008 SHALL perform all address arithmetic modulo 2^WIDTH, so pc+STEP wraps to 0 at the top of the address space.
REQ-009 trap SHALL act even while stall=1: pc<=TRAP_VECTOR, epc<=pc, RAS unchanged.
REQ-010 trap_return without trap SHALL act even while stall=1: pc<=epc, epc unchanged.
REQ-011 stall=1 without trap or trap_return SHALL hold pc, epc, RAS contents, RAS count and misaligned=0, while ignoring all other requests.
REQ-012 ret SHALL, when RAS is not empty, load pc with the top entry and decrement the count.
REQ-013 ret SHALL, when RAS is empty, load pc with pc+STEP, leave the count at 0 and set ras_underflow; ras_underflow SHALL be cleared only by reset.
REQ-014 call SHALL load pc with jump_target and push pc+STEP.
REQ-015 A push to a full RAS SHALL overwrite the oldest entry (circular) with the count staying RAS_DEPTH; no error flag SHALL be raised.
REQ-016 When ret and call are both asserted, ret SHALL win; call SHALL then be ignored and no push SHALL occur.
REQ-017 jump without call SHALL load jump_target with no RAS change.
REQ-018 When call and jump are both asserted, the result SHALL be identical to call alone.
REQ-019 A redirect target (branch, jump, call, or a RAS top on ret) whose low log2(STEP) bits are nonzero SHALL cause pc<=TRAP_VECTOR and epc<=the current pc.
REQ-020 For the REQ-019 case, misaligned SHALL pulse high for exactly the one cycle following the edge, and no RAS push or pop SHALL occur.
REQ-021 A sequential step and trap_return SHALL never raise misaligned.
REQ-022 pc_plus SHALL be combinational pc+STEP; every other output SHALL be registered or decoded from registered state.
REQ-023 The implementation SHALL contain no latches and no combinational path from any input to any output.

Reset
REQ-024 reset=1 SHALL immediately, without a clock edge, set pc=RESET_VECTOR, epc=0, RAS count=0, ras_empty=1, ras_full=0, misaligned=0 and ras_underflow=0.
REQ-025 Stored RAS entry contents after reset are don't-care and SHALL never be observable.
REQ-026 Reset asserted mid-operation, including during stall or a pending trap, SHALL override everything; on the first edge after deassertion, normal priority SHALL resume from RESET_VECTOR.

Verification
REQ-027 Bench SHALL cover reset then 3 idle edges (WIDTH=32, STEP=4) -> pc=0,4,8,12; pc_plus=pc+4.
REQ-028 Bench SHALL cover: at pc=0x10, call with jump_target=0x100; then at 0x100, ret -> pc=0x100 then 0x14; ras_empty=1 again.
REQ-029 Bench SHALL cover 5 calls with RAS_DEPTH=4 then 5 rets -> the first 4 rets return the last 4 pushed addresses in LIFO order; the 5th goes to pc+4 and sets ras_underflow=1.
REQ-030 Bench SHALL cover stall=1 together with branch_taken=1, branch_target=0x40 at pc=0x20 -> pc stays 0x20; then trap asserted with stall still 1 -> pc=0x80, epc=0x20; then trap_return -> pc=0x20.
REQ-031 Bench SHALL cover jump at pc=0x30 with jump_target=0x102 -> pc=0x80, epc=0x30, misaligned high for one cycle.
REQ-032 Bench SHALL cover pc=0xFFFFFFFC with an idle edge -> pc=0x00000000; and reset asserted between clock edges -> pc=0 immediately.
